// File: rtl/booth_ppgen_pipe.sv
// booth_ppgen_pipe: 2-stage radix-4 Booth encoder / partial-product generator.
// S1 registers A, tag and the Booth digits of B. S2 registers the NBIT/2 partial
// products in one's-complement form with a separate +1 bit and a sign-extension-prevention bit.
// Valid/ready on both sides. in_ready is combinational from out_ready, so a full pipe
// still accepts one op per cycle.
// Optional feature macro: BOOTH_PPGEN_REFPROD_EN adds out_ref_o, the signed product A*B,
// which travels alongside the partial products.
module booth_ppgen_pipe #(
    parameter int unsigned NBIT  = 10,
    parameter int unsigned TAG_W = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [NBIT-1:0]             in_a_i,
    input  logic [NBIT-1:0]             in_b_i,
    input  logic [TAG_W-1:0]            in_tag_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [(NBIT/2)*(NBIT+3)-1:0] out_ops_o,
    output logic [TAG_W-1:0]            out_tag_o
`ifdef BOOTH_PPGEN_REFPROD_EN
    ,
    output logic [2*NBIT-1:0]           out_ref_o
`endif
);

    localparam int NPP = NBIT / 2;
    localparam int PPW = NBIT + 3;

    // Digit encoding: 3-bit two's complement, values in {-2,-1,0,+1,+2}.
    function automatic logic [2:0] booth_digit(input logic [2:0] trip);
        logic [2:0] d;
        case (trip)
            3'b001, 3'b010: d = 3'b001;  // +1
            3'b011:         d = 3'b010;  // +2
            3'b100:         d = 3'b110;  // -2
            3'b101, 3'b110: d = 3'b111;  // -1
            default:        d = 3'b000;  // 000 / 111
        endcase
        return d;
    endfunction

    logic                          s1_valid_q, s1_valid_d;
    logic [NBIT-1:0]               s1_a_q, s1_a_d;
    logic [TAG_W-1:0]              s1_tag_q, s1_tag_d;
    logic [NPP-1:0][2:0]           s1_dig_q, s1_dig_d;

    logic                          s2_valid_q, s2_valid_d;
    logic [NPP-1:0][PPW-1:0]       s2_ops_q, s2_ops_d;
    logic [TAG_W-1:0]              s2_tag_q, s2_tag_d;

    logic                          s1_adv, s2_adv, in_fire;
    logic [NBIT:0]                 b_ext;
    logic [NPP-1:0][2:0]           dig_in;
    logic [NPP-1:0][NBIT:0]        pp_row;
    logic [NPP-1:0][PPW-1:0]       pp;

    assign s2_adv     = ~s2_valid_q | out_ready_i;
    assign s1_adv     = ~s1_valid_q | s2_adv;
    assign in_ready_o = s1_adv;
    assign in_fire    = in_valid_i & s1_adv;

    // b[-1] = 0 appended below the LSB of the multiplier.
    assign b_ext = {in_b_i, 1'b0};

    // Booth-recode the incoming multiplier into NPP digits.
    always_comb begin
        dig_in = '0;
        for (int i = 0; i < NPP; i++) begin
            dig_in[i] = booth_digit(b_ext[2*i +: 3]);
        end
    end

    // Partial products from the S1 digits; |d|*A is sign-extended to NBIT+1 bits so that
    // A = -2^(NBIT-1) with d = -2 still fits.
    always_comb begin
        pp_row = '0;
        pp     = '0;
        for (int i = 0; i < NPP; i++) begin
            if (s1_dig_q[i] == 3'b000) begin
                pp_row[i] = '0;
            end else if (s1_dig_q[i][1] & ~s1_dig_q[i][0]) begin
                pp_row[i] = {s1_a_q, 1'b0};
            end else begin
                pp_row[i] = {s1_a_q[NBIT-1], s1_a_q};
            end
            pp_row[i] = pp_row[i] ^ {(NBIT + 1){s1_dig_q[i][2]}};
            pp[i]     = {~pp_row[i][NBIT], s1_dig_q[i][2], pp_row[i]};
        end
    end

    // Next state for both stages; data registers load only on an actual transfer so
    // held outputs stay stable under backpressure.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_tag_d   = s1_tag_q;
        s1_dig_d   = s1_dig_q;
        s2_valid_d = s2_valid_q;
        s2_ops_d   = s2_ops_q;
        s2_tag_d   = s2_tag_q;
        if (s1_adv) begin
            s1_valid_d = in_valid_i;
            if (in_valid_i) begin
                s1_a_d   = in_a_i;
                s1_tag_d = in_tag_i;
                s1_dig_d = dig_in;
            end
        end
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_ops_d = pp;
                s2_tag_d = s1_tag_q;
            end
        end
    end

    // Pipeline registers; reset discards anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_tag_q   <= '0;
            s1_dig_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_ops_q   <= '0;
            s2_tag_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_tag_q   <= s1_tag_d;
            s1_dig_q   <= s1_dig_d;
            s2_valid_q <= s2_valid_d;
            s2_ops_q   <= s2_ops_d;
            s2_tag_q   <= s2_tag_d;
        end
    end

    assign out_valid_o = s2_valid_q;
    assign out_ops_o   = s2_ops_q;
    assign out_tag_o   = s2_tag_q;

`ifdef BOOTH_PPGEN_REFPROD_EN
    logic signed [2*NBIT-1:0] prod;
    logic [2*NBIT-1:0]        s1_ref_q, s2_ref_q;

    assign prod = $signed(in_a_i) * $signed(in_b_i);

    // Reference product rides along with the op, same load/hold rules as the data path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_ref_q <= '0;
            s2_ref_q <= '0;
        end else begin
            if (in_fire) s1_ref_q <= prod;
            if (s2_adv && s1_valid_q) s2_ref_q <= s1_ref_q;
        end
    end

    assign out_ref_o = s2_ref_q;
`else
    logic unused_fire;
    assign unused_fire = in_fire;
`endif

endmodule
